// File: rtl/m_sequence_despreader.sv
`default_nettype none
// ============================================================================
//  Module   : m_sequence_despreader
//  Purpose  : Receive-side despreader for an M-sequence spread link. Samples
//             one point per chip of the incoming chip stream, correlates it
//             against a local copy of the M-sequence started from a host seed
//             and reports the signed correlation once per frame.
//  Ports    : clkin, rstn (async, active low)
//             start_i, seed_i, ready_o            - host arm handshake
//             chip_i, strobe_i                    - received chip stream/frame
//             corr_o, bit_o, detect_o, abort_o,
//             result_valid_o                      - per-frame result
//  Revision : 1.0  initial release
// ============================================================================
module m_sequence_despreader #(
    parameter int                N        = 63,
    parameter int                LENGTH   = $clog2(N),
    parameter logic [LENGTH-1:0] POLYNOME = 6'b000011,
    parameter int                HOLD     = 3,
    parameter int                SAMPLE   = HOLD / 2,
    parameter int                THRESH   = 48,
    parameter int                CW       = LENGTH + 2
) (
    input  logic                 clkin,
    input  logic                 rstn,
    input  logic                 start_i,
    input  logic [LENGTH-1:0]    seed_i,
    output logic                 ready_o,
    input  logic                 chip_i,
    input  logic                 strobe_i,
    output logic signed [CW-1:0] corr_o,
    output logic                 bit_o,
    output logic                 detect_o,
    output logic                 abort_o,
    output logic                 result_valid_o
);

    localparam int HW   = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int CNTW = (N > 1) ? $clog2(N) : 1;

    localparam logic signed [CW-1:0] STEP_UP = {{(CW-1){1'b0}}, 1'b1};
    localparam logic signed [CW-1:0] STEP_DN = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 state;
    logic [LENGTH-1:0]      lfsr;
    logic [HW-1:0]          hold_cnt;
    logic [CNTW-1:0]        chip_cnt;
    logic signed [CW-1:0]   acc;
    logic                   strobe_q;

    // The rising-edge cycle in ARM is already chip 0 / cycle 0, so it must be
    // processed exactly like a RUN cycle with freshly cleared counters. The
    // muxes below present that cleared view so a single datapath covers both
    // (this also makes SAMPLE == 0 work without a special case).
    logic                   first_chip;
    logic                   in_frame;
    logic [HW-1:0]          pos_hold;
    logic [CNTW-1:0]        pos_chip;
    logic signed [CW-1:0]   acc_base;
    logic                   sample_now;
    logic                   last_sample;
    logic signed [CW-1:0]   acc_next;
    logic [CW-1:0]          acc_mag;
    logic                   feedback;
    logic                   chip_end;

    assign first_chip  = (state == ARM) && strobe_i && !strobe_q;
    assign in_frame    = first_chip || ((state == RUN) && strobe_i);
    assign pos_hold    = first_chip ? '0 : hold_cnt;
    assign pos_chip    = first_chip ? '0 : chip_cnt;
    assign acc_base    = first_chip ? '0 : acc;
    assign sample_now  = in_frame && (pos_hold == HW'(SAMPLE));
    assign last_sample = sample_now && (pos_chip == CNTW'(N - 1));
    assign chip_end    = (pos_hold == HW'(HOLD - 1));
    assign feedback    = ^(POLYNOME & lfsr);

    always_comb begin
        acc_next = acc_base;
        if (sample_now) begin
            acc_next = acc_base + ((chip_i == lfsr[0]) ? STEP_UP : STEP_DN);
        end
    end

    // Magnitude via two's-complement negation; acc never reaches -2^(CW-1).
    assign acc_mag = acc_next[CW-1] ? CW'(-acc_next) : CW'(acc_next);

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            lfsr           <= {{(LENGTH-1){1'b0}}, 1'b1};
            hold_cnt       <= '0;
            chip_cnt       <= '0;
            acc            <= '0;
            strobe_q       <= 1'b0;
            ready_o        <= 1'b1;
            corr_o         <= '0;
            bit_o          <= 1'b0;
            detect_o       <= 1'b0;
            abort_o        <= 1'b0;
            result_valid_o <= 1'b0;
        end else begin
            strobe_q       <= strobe_i;
            result_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        // An all-zero state would lock the LFSR; substitute 1.
                        lfsr    <= (seed_i == '0) ? {{(LENGTH-1){1'b0}}, 1'b1} : seed_i;
                        ready_o <= 1'b0;
                        state   <= ARM;
                    end
                end
                ARM, RUN: begin
                    if ((state == RUN) && !strobe_i) begin
                        // Frame cut short: report the partial sum, never a detect.
                        corr_o         <= acc;
                        bit_o          <= acc[CW-1];
                        detect_o       <= 1'b0;
                        abort_o        <= 1'b1;
                        result_valid_o <= 1'b1;
                        ready_o        <= 1'b1;
                        state          <= IDLE;
                    end else if (in_frame) begin
                        acc      <= acc_next;
                        hold_cnt <= chip_end ? '0 : pos_hold + HW'(1);
                        chip_cnt <= chip_end ? pos_chip + CNTW'(1) : pos_chip;
                        if (sample_now) begin
                            lfsr <= {feedback, lfsr[LENGTH-1:1]};
                        end
                        state <= RUN;
                        if (last_sample) begin
                            corr_o         <= acc_next;
                            bit_o          <= acc_next[CW-1];
                            detect_o       <= (acc_mag >= CW'(THRESH));
                            abort_o        <= 1'b0;
                            result_valid_o <= 1'b1;
                            ready_o        <= 1'b1;
                            state          <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Tail cycles of the last chip are ignored; start_i is not
                    // taken here even though ready_o is already high.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_m_sequence_despreader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_m_sequence_despreader
//  Purpose  : Self-checking bench for m_sequence_despreader. A reference model
//             builds the M-sequence from its linear recurrence and derives the
//             expected correlation, result timing and flags for each frame.
//  Revision : 1.0  initial release
// ============================================================================
module tb_m_sequence_despreader;

    localparam int         N      = 63;
    localparam int         L      = 6;
    localparam logic [5:0] POLY   = 6'b000011;
    localparam int         HOLD   = 3;
    localparam int         SAMPLE = HOLD / 2;
    localparam int         THRESH = 48;
    localparam int         CW     = L + 2;

    logic                 clkin;
    logic                 rstn;
    logic                 start_i;
    logic [L-1:0]         seed_i;
    logic                 ready_o;
    logic                 chip_i;
    logic                 strobe_i;
    logic signed [CW-1:0] corr_o;
    logic                 bit_o;
    logic                 detect_o;
    logic                 abort_o;
    logic                 result_valid_o;

    int total = 0;
    int bad   = 0;

    m_sequence_despreader dut (
        .clkin          (clkin),
        .rstn           (rstn),
        .start_i        (start_i),
        .seed_i         (seed_i),
        .ready_o        (ready_o),
        .chip_i         (chip_i),
        .strobe_i       (strobe_i),
        .corr_o         (corr_o),
        .bit_o          (bit_o),
        .detect_o       (detect_o),
        .abort_o        (abort_o),
        .result_valid_o (result_valid_o)
    );

    initial begin
        clkin = 1'b0;
        forever #5 clkin = ~clkin;
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Element k of the M-sequence whose first L elements are the bits of st:
    // s[k+L] = XOR of s[k+i] over every tap i.
    function automatic bit mseq(input logic [L-1:0] st, input int k);
        bit s [0:255];
        bit x;
        for (int i = 0; i < L; i++) s[i] = st[i];
        for (int j = L; j <= k; j++) begin
            x = 1'b0;
            for (int i = 0; i < L; i++) begin
                if (POLY[i]) x = x ^ s[j-L+i];
            end
            s[j] = x;
        end
        return s[k];
    endfunction

    // One frame: arm with seed, drive a stream built from sst advanced by
    // offset chips (optionally inverted / randomly corrupted) with strobe_i
    // high for scyc cycles. busy_at / reset_at (>=0) inject a start_i while
    // busy or an async reset at that cycle.
    task automatic run_frame(input string nm, input logic [L-1:0] seed,
                             input logic [L-1:0] sst, input int offset,
                             input bit inv, input int flip_pct, input int scyc,
                             input int busy_at, input int reset_at);
        bit         ref_a [0:N-1];
        bit         tx_a  [0:N-1];
        logic [L-1:0] rs;
        int  exp_corr, exp_vc, final_c, win, nval, vc;
        int  got_corr, got_bit, got_det, got_abt, exp_det;
        bit  full, ok;

        rs = (seed == '0) ? 6'd1 : seed;
        for (int k = 0; k < N; k++) begin
            ref_a[k] = mseq(rs, k);
            tx_a[k]  = mseq(sst, k + offset) ^ inv ^ ($urandom_range(0, 99) < flip_pct);
        end
        final_c  = (N - 1) * HOLD + SAMPLE;
        full     = (scyc > final_c);
        exp_corr = 0;
        for (int k = 0; k < N; k++) begin
            if (k * HOLD + SAMPLE < scyc) exp_corr += (tx_a[k] == ref_a[k]) ? 1 : -1;
        end
        exp_vc  = full ? final_c + 1 : scyc + 1;
        exp_det = (full && (exp_corr >= THRESH || -exp_corr >= THRESH)) ? 1 : 0;

        strobe_i = 1'b0;
        start_i  = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clkin);
            ok = ready_o;
        end
        check({nm, ".ready_wait"}, int'(ok), 1);
        if (!ok) return;

        start_i = 1'b1;
        seed_i  = seed;
        @(negedge clkin);
        start_i = 1'b0;
        seed_i  = L'($urandom);
        check({nm, ".armed_busy"}, int'(ready_o), 0);

        win  = ((scyc > final_c + 1) ? scyc : final_c + 1) + 4;
        nval = 0;
        vc   = -1;
        got_corr = 0; got_bit = 0; got_det = 0; got_abt = 0;
        for (int c = 0; c < win; c++) begin
            @(negedge clkin);
            if (result_valid_o) begin
                nval++;
                if (nval == 1) begin
                    vc       = c;
                    got_corr = int'(corr_o);
                    got_bit  = int'(bit_o);
                    got_det  = int'(detect_o);
                    got_abt  = int'(abort_o);
                end
            end
            if (vc >= 0 && c == vc + 1) begin
                check({nm, ".ready_after"}, int'(ready_o), 1);
                check({nm, ".valid_pulse"}, int'(result_valid_o), 0);
            end
            if (c == reset_at + 1 && reset_at >= 0) rstn = 1'b1;
            if (c == busy_at) begin
                check({nm, ".busy_ready"}, int'(ready_o), 0);
                start_i = 1'b1;
                seed_i  = ~seed;
            end else begin
                start_i = 1'b0;
            end
            strobe_i = (c < scyc);
            chip_i   = (c < scyc && c / HOLD < N) ? tx_a[c / HOLD] : 1'b0;
            if (c == reset_at) begin
                rstn = 1'b0;
                #1;
                check({nm, ".rst_ready"}, int'(ready_o), 1);
                check({nm, ".rst_valid"}, int'(result_valid_o), 0);
                check({nm, ".rst_corr"}, int'(corr_o), 0);
            end
        end
        strobe_i = 1'b0;
        start_i  = 1'b0;

        if (reset_at >= 0) begin
            check({nm, ".no_result"}, nval, 0);
        end else begin
            check({nm, ".n_results"}, nval, 1);
            check({nm, ".latency"}, vc, exp_vc);
            check({nm, ".corr"}, got_corr, exp_corr);
            check({nm, ".bit"}, got_bit, (exp_corr < 0) ? 1 : 0);
            check({nm, ".detect"}, got_det, exp_det);
            check({nm, ".abort"}, got_abt, full ? 0 : 1);
            check({nm, ".corr_hold"}, int'(corr_o), exp_corr);
        end
    endtask

    initial begin
        rstn     = 1'b0;
        start_i  = 1'b0;
        seed_i   = '0;
        chip_i   = 1'b0;
        strobe_i = 1'b0;
        repeat (3) @(negedge clkin);
        check("reset.ready", int'(ready_o), 1);
        check("reset.corr", int'(corr_o), 0);
        check("reset.bit", int'(bit_o), 0);
        check("reset.detect", int'(detect_o), 0);
        check("reset.abort", int'(abort_o), 0);
        check("reset.valid", int'(result_valid_o), 0);
        rstn = 1'b1;
        @(negedge clkin);

        run_frame("match",   6'b101010, 6'b101010, 0, 1'b0, 0, 189, -1, -1);
        run_frame("invert",  6'b101010, 6'b101010, 0, 1'b1, 0, 189, -1, -1);
        run_frame("offset1", 6'b101010, 6'b101010, 1, 1'b0, 0, 189, -1, -1);
        run_frame("seed0",   6'b000000, 6'b000001, 0, 1'b0, 0, 189, -1, -1);
        run_frame("abort21", 6'b101010, 6'b101010, 0, 1'b0, 0, 21 * HOLD, -1, -1);
        run_frame("rstmid",  6'b101010, 6'b101010, 0, 1'b0, 0, 189, -1, 30 * HOLD);
        run_frame("busystart", 6'b110011, 6'b110011, 0, 1'b0, 0, 189, 50, -1);

        for (int r = 0; r < 8; r++) begin
            logic [L-1:0] sd;
            int           len;
            sd  = L'($urandom);
            len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(10, 187))
                                              : int'($urandom_range(188, 194));
            run_frame($sformatf("rand%0d", r), sd, (sd == '0) ? 6'd1 : sd, 0,
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 30)), len, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
